// File: rtl/usb_spi_pkg.sv
// Shared constants and FSM state type for the USB SPI byte sequencer.
package usb_spi_pkg;

   localparam logic [1:0] ADDR_TX   = 2'd0;
   localparam logic [1:0] ADDR_RX   = 2'd1;
   localparam logic [1:0] ADDR_STAT = 2'd2;
   localparam logic [1:0] ADDR_CTRL = 2'd3;

   localparam int unsigned STAT_BUSY = 0;
   localparam int unsigned STAT_DONE = 1;
   localparam int unsigned STAT_OVR  = 2;

   localparam int unsigned CTRL_CS_EN  = 8;
   localparam int unsigned CTRL_IRQ_EN = 9;

   typedef enum logic [1:0] {
      StIdle,
      StLow,
      StHigh
   } state_e;

endpackage

// File: rtl/usb_spi_clkgen.sv
// Half-period timer for the SPI clock: pulses half_tick when the counter reaches
// the divider value latched at transfer start.
module usb_spi_clkgen #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   output logic             half_tick
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] div_q;

   assign half_tick = run & (cnt_q == div_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         div_q <= '0;
      end else begin
         if (start) begin
            div_q <= div;
         end
         // Every tick is a state change in the FSM, so the count restarts.
         if (start || half_tick || !run) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/usb_spi_sequencer.sv
// Avalon-MM SPI byte engine (mode 0, MSB first) for the USB host controller link.
// Define USB_SPI_IRQ_EN to add the irq output and the CONTROL irq_en bit.
module usb_spi_sequencer
   import usb_spi_pkg::*;
#(
   parameter int unsigned      DIV_W       = 8,
   parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(4)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        usb_sdi,
   output logic        usb_sck,
   output logic        usb_sdo,
   output logic        usb_cs_n
`ifdef USB_SPI_IRQ_EN
   ,
   output logic        irq
`endif
);

   state_e           state_q;
   logic             sck_q, sdo_q, done_q, ovr_q, cs_n_q;
   logic [6:0]       tx_sh_q;
   logic [7:0]       rx_sh_q, rx_q;
   logic [2:0]       bit_cnt_q;
   logic [DIV_W-1:0] div_q;
   logic             busy, wr_en, tx_wr, stat_wr, ctrl_wr, start, half_tick;

   assign wr_en   = chipselect & ~write_n;
   assign tx_wr   = wr_en & (address == ADDR_TX);
   assign stat_wr = wr_en & (address == ADDR_STAT);
   assign ctrl_wr = wr_en & (address == ADDR_CTRL);
   assign busy    = (state_q != StIdle);
   assign start   = tx_wr & ~busy;

   usb_spi_clkgen #(
      .DIV_W (DIV_W)
   ) u_clkgen (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .run       (busy),
      .div       (div_q),
      .half_tick (half_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         sck_q     <= 1'b0;
         sdo_q     <= 1'b0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_q      <= '0;
         bit_cnt_q <= '0;
      end else begin
         if (stat_wr) begin
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
         end
         if (tx_wr && busy) begin
            ovr_q <= 1'b1;
         end
         // Completion below overrides a same-cycle STATUS clear of done.
         unique case (state_q)
            StIdle: begin
               if (tx_wr) begin
                  tx_sh_q   <= writedata[6:0];
                  sdo_q     <= writedata[7];
                  sck_q     <= 1'b0;
                  bit_cnt_q <= '0;
                  done_q    <= 1'b0;
                  state_q   <= StLow;
               end
            end
            StLow: begin
               if (half_tick) begin
                  sck_q   <= 1'b1;
                  rx_sh_q <= {rx_sh_q[6:0], usb_sdi};
                  state_q <= StHigh;
               end
            end
            StHigh: begin
               if (half_tick) begin
                  sck_q <= 1'b0;
                  if (bit_cnt_q == 3'd7) begin
                     done_q  <= 1'b1;
                     rx_q    <= rx_sh_q;
                     state_q <= StIdle;
                  end else begin
                     sdo_q     <= tx_sh_q[6];
                     tx_sh_q   <= {tx_sh_q[5:0], 1'b0};
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     state_q   <= StLow;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef USB_SPI_IRQ_EN
   logic irq_en_q, irq_q;
   logic unused_wdata;
   assign unused_wdata = ^writedata[31:10];
`else
   logic unused_wdata;
   assign unused_wdata = ^writedata[31:9];
`endif

   // CONTROL applies immediately; the clkgen latches div only at transfer start.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q  <= DEFAULT_DIV;
         cs_n_q <= 1'b1;
`ifdef USB_SPI_IRQ_EN
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
`endif
      end else begin
         if (ctrl_wr) begin
            div_q  <= writedata[DIV_W-1:0];
            cs_n_q <= ~writedata[CTRL_CS_EN];
`ifdef USB_SPI_IRQ_EN
            irq_en_q <= writedata[CTRL_IRQ_EN];
`endif
         end
`ifdef USB_SPI_IRQ_EN
         if (stat_wr) begin
            irq_q <= 1'b0;
         end else begin
            irq_q <= done_q & irq_en_q;
         end
`endif
      end
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         ADDR_RX:   readdata[7:0] = rx_q;
         ADDR_STAT: begin
            readdata[STAT_BUSY] = busy;
            readdata[STAT_DONE] = done_q;
            readdata[STAT_OVR]  = ovr_q;
         end
         ADDR_CTRL: begin
            readdata[DIV_W-1:0]  = div_q;
            readdata[CTRL_CS_EN] = ~cs_n_q;
`ifdef USB_SPI_IRQ_EN
            readdata[CTRL_IRQ_EN] = irq_en_q;
`endif
         end
         default:   readdata = '0;
      endcase
   end

   assign usb_sck  = sck_q;
   assign usb_sdo  = sdo_q;
   assign usb_cs_n = cs_n_q;
`ifdef USB_SPI_IRQ_EN
   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_usb_spi_sequencer.sv
// Self-checking bench for usb_spi_sequencer: vector table of transfers plus
// hand-written corner sequences, with an SDO byte scoreboard fed at each TX write.
module tb_usb_spi_sequencer;
   import usb_spi_pkg::*;

   logic        clk, reset, chipselect, write_n, usb_sdi, usb_sck, usb_sdo, usb_cs_n;
   logic [1:0]  address;
   logic [31:0] writedata, readdata;
   logic [1:0]  sdi_mode;  // 0: loop SDO back, 1: constant 1, 2: constant 0
`ifdef USB_SPI_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int failures = 0;
   int cur_div = 4;
   logic [7:0] exp_q[$];

   assign usb_sdi = (sdi_mode == 2'd0) ? usb_sdo : (sdi_mode == 2'd1);

   usb_spi_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .usb_sdi    (usb_sdi),
      .usb_sck    (usb_sck),
      .usb_sdo    (usb_sdo),
      .usb_cs_n   (usb_cs_n)
`ifdef USB_SPI_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      #1;
      d = readdata;
      chipselect = 1'b0;
   endtask

   task automatic wait_idle(output int cycles);
      logic [31:0] s;
      cycles = 0;
      forever begin
         rd(ADDR_STAT, s);
         if (!s[STAT_BUSY]) break;
         cycles++;
         if (cycles > 5000) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout actual=busy expected=idle");
            break;
         end
         @(negedge clk);
      end
   endtask

   // SDO scoreboard: one byte of bits per 8 SCK rising edges.
   int         mon_cnt = 0;
   logic [7:0] mon_sdo;
   time        rise_t;
   always @(posedge usb_sck or posedge reset) begin
      if (reset) begin
         mon_cnt = 0;
      end else begin
         rise_t  = $time;
         mon_sdo = {mon_sdo[6:0], usb_sdo};
         mon_cnt++;
         if (mon_cnt == 8) begin
            mon_cnt = 0;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sdo_unexpected actual=0x%0h expected=none", mon_sdo);
            end else begin
               check("sdo_byte", {24'd0, mon_sdo}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   always @(negedge usb_sck) begin
      if (!reset) check("sck_high_cycles", 32'(($time - rise_t) / 10), 32'(cur_div + 1));
   end

   typedef struct {
      int         div;
      logic [7:0] tx;
      logic [1:0] sdi;
      logic [7:0] rx;
      int         busy;
   } vec_t;

   vec_t        vecs[4];
   logic [31:0] d;
   int          n;

   initial begin
      vecs[0] = '{div: 4, tx: 8'hA5, sdi: 2'd0, rx: 8'hA5, busy: 80};
      vecs[1] = '{div: 0, tx: 8'h3C, sdi: 2'd1, rx: 8'hFF, busy: 16};
      vecs[2] = '{div: 1, tx: 8'h5A, sdi: 2'd2, rx: 8'h00, busy: 32};
      vecs[3] = '{div: 2, tx: 8'hC3, sdi: 2'd0, rx: 8'hC3, busy: 48};

      reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
      sdi_mode = 2'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      rd(ADDR_STAT, d); check("rst_status", d, 32'h0);
      rd(ADDR_RX, d);   check("rst_rxdata", d, 32'h0);
      rd(ADDR_CTRL, d); check("rst_control", d, 32'h4);
      rd(ADDR_TX, d);   check("rst_txdata_read", d, 32'h0);
      check("rst_cs_n", {31'd0, usb_cs_n}, 32'h1);
      check("rst_sck", {31'd0, usb_sck}, 32'h0);
      check("rst_sdo", {31'd0, usb_sdo}, 32'h0);

      for (int i = 0; i < 4; i++) begin
         sdi_mode = vecs[i].sdi;
         cur_div  = vecs[i].div;
         wr(ADDR_CTRL, 32'h100 | 32'(vecs[i].div));
         check("cs_n_sw", {31'd0, usb_cs_n}, 32'h0);
         exp_q.push_back(vecs[i].tx);
         wr(ADDR_TX, {24'd0, vecs[i].tx});
         wait_idle(n);
         check("busy_cycles", 32'(n), 32'(vecs[i].busy));
         rd(ADDR_RX, d);   check("vec_rxdata", d, {24'd0, vecs[i].rx});
         rd(ADDR_STAT, d); check("vec_status", d, 32'h2);
      end

      // STATUS write landing on the completion edge: done must survive.
      sdi_mode = 2'd2;
      cur_div  = 0;
      wr(ADDR_CTRL, 32'h100);
      exp_q.push_back(8'h81);
      wr(ADDR_TX, 32'h81);
      repeat (14) @(negedge clk);
      wr(ADDR_STAT, 32'h0);
      rd(ADDR_STAT, d); check("stat_wr_vs_done", d, 32'h2);
      rd(ADDR_RX, d);   check("collide_rxdata", d, 32'h0);
      wr(ADDR_STAT, 32'h0);
      rd(ADDR_STAT, d); check("status_clear", d, 32'h0);

      // Reset 30 cycles into a div=4 transfer.
      cur_div = 4;
      wr(ADDR_CTRL, 32'h104);
      wr(ADDR_TX, 32'hF0);
      repeat (29) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rd(ADDR_STAT, d); check("midrst_status", d, 32'h0);
      rd(ADDR_RX, d);   check("midrst_rxdata", d, 32'h0);
      rd(ADDR_CTRL, d); check("midrst_control", d, 32'h4);
      check("midrst_sck", {31'd0, usb_sck}, 32'h0);
      check("midrst_cs_n", {31'd0, usb_cs_n}, 32'h1);

      // Overrun: second TXDATA write while busy is dropped.
      sdi_mode = 2'd0;
      wr(ADDR_CTRL, 32'h104);
      exp_q.push_back(8'h11);
      wr(ADDR_TX, 32'h11);
      wr(ADDR_TX, 32'h22);
      rd(ADDR_STAT, d); check("ovr_busy_status", d, 32'h5);
      wait_idle(n);
      rd(ADDR_STAT, d); check("ovr_done_status", d, 32'h6);
      rd(ADDR_RX, d);   check("ovr_rxdata", d, 32'h11);
      wr(ADDR_STAT, 32'hFFFF_FFFF);
      rd(ADDR_STAT, d); check("ovr_cleared", d, 32'h0);

      wr(ADDR_CTRL, 32'h304);
      rd(ADDR_CTRL, d);
`ifdef USB_SPI_IRQ_EN
      check("ctrl_bit9", d, 32'h304);
      exp_q.push_back(8'hE7);
      wr(ADDR_TX, 32'hE7);
      n = 0;
      forever begin
         rd(ADDR_STAT, d);
         if (d[STAT_DONE]) begin
            check("irq_same_cycle_as_done", {31'd0, irq}, 32'h0);
            @(negedge clk);
            check("irq_after_done", {31'd0, irq}, 32'h1);
            break;
         end
         n++;
         if (n > 5000) begin
            checks++;
            failures++;
            $display("FAIL irq_done_timeout actual=busy expected=done");
            break;
         end
         @(negedge clk);
      end
      wr(ADDR_STAT, 32'h0);
      check("irq_cleared", {31'd0, irq}, 32'h0);
`else
      check("ctrl_bit9", d, 32'h104);
`endif

      repeat (4) @(negedge clk);
      check("sdo_queue_empty", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
